// File: rtl/p22_tex_qspi_sched.sv
// Two-requester scheduler for the texture flash: arbitrates, then runs one Quad Output Fast Read per grant.
// Optional feature macro: TEX_SCHED_RR_EN (round-robin arbitration; fixed priority to req0 when undefined).
module p22_tex_qspi_sched #(
    parameter int         ADDR_W    = 24,
    parameter int         DUMMY_CYC = 8,
    parameter int         MIN_GAP   = 2,
    parameter logic [7:0] CMD       = 8'h6B
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_req0,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic              i_req1,
    input  logic [ADDR_W-1:0] i_addr1,
    output logic              o_ack0,
    output logic              o_ack1,
    output logic [7:0]        o_data,
    output logic              o_busy,
    output logic              o_tex_csb,
    output logic              o_tex_sclk,
    output logic              o_tex_oeb0,
    output logic              o_tex_out0,
    input  logic [3:0]        i_tex_in
);

    localparam int M1      = (ADDR_W > 8) ? ADDR_W : 8;
    localparam int M2      = (DUMMY_CYC > M1) ? DUMMY_CYC : M1;
    localparam int CNT_MAX = (MIN_GAP > M2) ? MIN_GAP : M2;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int SH_W    = 8 + ADDR_W;

    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(7);
    localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'(DUMMY_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(MIN_GAP - 1);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_GAP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ph_q, ph_d;        // 0 = phase L (sclk low), 1 = phase H
    logic [SH_W-1:0]  sh_q, sh_d;        // bits still to be shifted out after out0
    logic             id_q, id_d;
    logic [3:0]       nib_q, nib_d;
    logic             csb_q, csb_d, sclk_q, sclk_d, oeb0_q, oeb0_d, out0_q, out0_d;
    logic             ack0_q, ack0_d, ack1_q, ack1_d, busy_q, busy_d;
    logic [7:0]       data_q, data_d;
    logic             grant1;

`ifdef TEX_SCHED_RR_EN
    logic last_q, last_d;                // id granted on the most recent accept
    assign grant1 = i_req1 & (~i_req0 | ~last_q);
`else
    assign grant1 = i_req1 & ~i_req0;
`endif

    // NOTE: every *_d gets its hold value first, so no path through this block can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        sh_d    = sh_q;
        id_d    = id_q;
        nib_d   = nib_q;
        csb_d   = csb_q;
        sclk_d  = sclk_q;
        oeb0_d  = oeb0_q;
        out0_d  = out0_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        busy_d  = busy_q;
        data_d  = data_q;
`ifdef TEX_SCHED_RR_EN
        last_d  = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_req0 || i_req1) begin
                    state_d = S_CMD;
                    id_d    = grant1;
                    sh_d    = {CMD[6:0], (grant1 ? i_addr1 : i_addr0), 1'b0};
                    out0_d  = CMD[7];
                    csb_d   = 1'b0;
                    sclk_d  = 1'b0;
                    oeb0_d  = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    ph_d    = 1'b0;
`ifdef TEX_SCHED_RR_EN
                    last_d  = grant1;
`endif
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
                if (!ph_q) begin
                    ph_d   = 1'b1;
                    sclk_d = 1'b1;
                end else begin
                    // End of phase H: next bit goes out and the flash nibble is sampled.
                    ph_d   = 1'b0;
                    sclk_d = 1'b0;
                    cnt_d  = cnt_q + 1'b1;
                    case (state_q)
                        S_CMD: begin
                            out0_d = sh_q[SH_W-1];
                            sh_d   = {sh_q[SH_W-2:0], 1'b0};
                            if (cnt_q == CMD_LAST) begin
                                state_d = S_ADDR;
                                cnt_d   = '0;
                            end
                        end
                        S_ADDR: begin
                            if (cnt_q == ADDR_LAST) begin
                                state_d = S_DUMMY;
                                cnt_d   = '0;
                                out0_d  = 1'b0;
                                oeb0_d  = 1'b1;
                            end else begin
                                out0_d = sh_q[SH_W-1];
                                sh_d   = {sh_q[SH_W-2:0], 1'b0};
                            end
                        end
                        S_DUMMY: begin
                            if (cnt_q == DUMMY_LAST) begin
                                state_d = S_DATA;
                                cnt_d   = '0;
                            end
                        end
                        S_DATA: begin
                            if (cnt_q == '0) begin
                                nib_d = i_tex_in;
                            end else begin
                                data_d  = {nib_q, i_tex_in};
                                ack0_d  = ~id_q;
                                ack1_d  = id_q;
                                csb_d   = 1'b1;
                                oeb0_d  = 1'b0;
                                state_d = S_GAP;
                                cnt_d   = '0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ph_q    <= 1'b0;
            sh_q    <= '0;
            id_q    <= 1'b0;
            nib_q   <= '0;
            csb_q   <= 1'b1;
            sclk_q  <= 1'b0;
            oeb0_q  <= 1'b0;
            out0_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
`ifdef TEX_SCHED_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            sh_q    <= sh_d;
            id_q    <= id_d;
            nib_q   <= nib_d;
            csb_q   <= csb_d;
            sclk_q  <= sclk_d;
            oeb0_q  <= oeb0_d;
            out0_q  <= out0_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
`ifdef TEX_SCHED_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    assign o_ack0     = ack0_q;
    assign o_ack1     = ack1_q;
    assign o_data     = data_q;
    assign o_busy     = busy_q;
    assign o_tex_csb  = csb_q;
    assign o_tex_sclk = sclk_q;
    assign o_tex_oeb0 = oeb0_q;
    assign o_tex_out0 = out0_q;

endmodule

// File: tb/tb_p22_tex_qspi_sched.sv
// Bench for p22_tex_qspi_sched: a behavioural flash model on the pads plus a transaction-level arbiter model.
module tb_p22_tex_qspi_sched;

    localparam int MIN_GAP = 2;
    localparam int LAT     = 2 * (8 + 24 + 8 + 2);
    localparam int SPACING = LAT + MIN_GAP + 1;

    logic        i_clk = 1'b0, i_reset_n = 1'b1;
    logic        i_req0 = 1'b0, i_req1 = 1'b0;
    logic [23:0] i_addr0 = '0, i_addr1 = '0;
    logic [3:0]  i_tex_in = '0;
    logic        o_ack0, o_ack1, o_busy, o_tex_csb, o_tex_sclk, o_tex_oeb0, o_tex_out0;
    logic [7:0]  o_data;

    p22_tex_qspi_sched dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_req0(i_req0), .i_addr0(i_addr0), .i_req1(i_req1), .i_addr1(i_addr1),
        .o_ack0(o_ack0), .o_ack1(o_ack1), .o_data(o_data), .o_busy(o_busy),
        .o_tex_csb(o_tex_csb), .o_tex_sclk(o_tex_sclk), .o_tex_oeb0(o_tex_oeb0),
        .o_tex_out0(o_tex_out0), .i_tex_in(i_tex_in)
    );

    always #5 i_clk = ~i_clk;

    // One completed transaction as seen on the pads and ack port.
    typedef struct packed {
        logic        id;
        logic        both;
        logic [7:0]  data;
        logic [31:0] word;
        logic [7:0]  lat;
        logic [7:0]  rises;
        logic        oeb_bad;
        logic [2:0]  pads;
    } txn_t;

    int n_checks = 0, n_pass = 0, cyc = 0;
    bit prev_csb = 1'b1, prev_sclk = 1'b0, oeb_bad = 1'b0, ack_seen = 1'b0, model_last = 1'b1;
    int rise_cnt = 0, start_cyc = 0, high_run = 0, last_gap = 0, ack_cyc = 0, ack_gap = 0;
    logic [31:0] word = '0;
    logic [7:0]  cur_byte = '0, next_byte = '0, ack_fbyte = '0;
    txn_t        ack_obs;

    always @(posedge i_clk) cyc++;

    // Flash model and pad monitor, evaluated mid-cycle.
    always @(negedge i_clk) begin
        if (!i_reset_n) begin
            prev_csb  = 1'b1;
            prev_sclk = 1'b0;
        end else begin
            if (prev_csb && !o_tex_csb) begin
                rise_cnt  = 0;
                word      = '0;
                oeb_bad   = 1'b0;
                start_cyc = cyc;
                last_gap  = high_run;
                high_run  = 0;
                cur_byte  = next_byte;
                next_byte = 8'($urandom);
            end
            if (o_tex_csb) high_run++;
            if (!o_tex_csb && o_tex_sclk && !prev_sclk) begin
                rise_cnt++;
                if (rise_cnt <= 32) begin
                    word = {word[30:0], o_tex_out0};
                    if (o_tex_oeb0 !== 1'b0) oeb_bad = 1'b1;
                end else if (o_tex_oeb0 !== 1'b1) begin
                    oeb_bad = 1'b1;
                end
                i_tex_in = (rise_cnt == 41) ? cur_byte[7:4] :
                           (rise_cnt == 42) ? cur_byte[3:0] : 4'($urandom);
            end
            if (o_ack0 || o_ack1) begin
                ack_seen        = 1'b1;
                ack_obs.id      = o_ack1;
                ack_obs.both    = o_ack0 & o_ack1;
                ack_obs.data    = o_data;
                ack_obs.word    = word;
                ack_obs.lat     = 8'(cyc - start_cyc);
                ack_obs.rises   = 8'(rise_cnt);
                ack_obs.oeb_bad = oeb_bad;
                ack_obs.pads    = {o_tex_csb, o_tex_sclk, o_tex_oeb0};
                ack_fbyte       = cur_byte;
                ack_cyc         = cyc;
                ack_gap         = last_gap;
            end
            prev_csb  = o_tex_csb;
            prev_sclk = o_tex_sclk;
        end
    end

    // Arbitration rule: who wins an accept given the pending requests.
    function automatic bit model_grant(input bit r0, input bit r1);
`ifdef TEX_SCHED_RR_EN
        if (r0 && r1) return !model_last;
`endif
        return r1 && !r0;
    endfunction

    function automatic txn_t make_exp(input bit id, input logic [7:0] data, input logic [23:0] addr);
        txn_t e;
        e.id = id;  e.both = 1'b0;  e.data = data;  e.word = {8'h6B, addr};
        e.lat = 8'(LAT);  e.rises = 8'd42;  e.oeb_bad = 1'b0;  e.pads = 3'b100;
        return e;
    endfunction

    task automatic wait_txn(output txn_t o, output logic [7:0] fb, output int ac, output int gp, output bit to);
        to = 1'b1;  o = '0;  fb = '0;  ac = 0;  gp = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge i_clk); #1;
            if (ack_seen) begin
                ack_seen = 1'b0;
                o = ack_obs;  fb = ack_fbyte;  ac = ack_cyc;  gp = ack_gap;  to = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (!o_busy) break;
            @(posedge i_clk); #1;
        end
    endtask

    task automatic test_reset();
        #3 i_reset_n = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        n_checks++;
        if ({o_tex_csb, o_tex_sclk, o_tex_oeb0, o_tex_out0, o_ack0, o_ack1, o_busy, o_data} !== {1'b1, 6'b0, 8'h00})
            $display("FAIL reset_state: got %b, expected %b",
                     {o_tex_csb, o_tex_sclk, o_tex_oeb0, o_tex_out0, o_ack0, o_ack1, o_busy, o_data}, {1'b1, 14'b0});
        else n_pass++;
        @(negedge i_clk); #2 i_reset_n = 1'b1;
        model_last = 1'b1;
    endtask

    task automatic test_single_read();
        txn_t o, e; logic [7:0] fb; int ac, gp; bit to, g;
        wait_idle();
        next_byte = 8'hA5;
        i_addr0 = 24'h123456;  i_req0 = 1'b1;
        g = model_grant(1'b1, 1'b0);
        wait_txn(o, fb, ac, gp, to);
        i_req0 = 1'b0;  model_last = g;
        e = make_exp(g, 8'hA5, 24'h123456);
        n_checks++;
        if (to) $display("FAIL single_read: no ack within bound");
        else if (o !== e) $display("FAIL single_read: got %h, expected %h", o, e);
        else n_pass++;
        n_checks++;
        if (o_busy !== 1'b1) $display("FAIL busy_in_gap: got %b, expected 1", o_busy);
        else n_pass++;
        repeat (MIN_GAP - 1) @(posedge i_clk);
        #1;
        n_checks++;
        if (o_busy !== 1'b0) $display("FAIL busy_after_gap: got %b, expected 0", o_busy);
        else n_pass++;
    endtask

    task automatic test_contention();
        txn_t o, e; logic [7:0] fb; int ac, ac_first, gp; bit to, g;
        wait_idle();
        i_addr0 = 24'($urandom);  i_addr1 = 24'($urandom);
        i_req0 = 1'b1;  i_req1 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            g = model_grant(i_req0, i_req1);
            e = make_exp(g, 8'h00, g ? i_addr1 : i_addr0);
            wait_txn(o, fb, ac, gp, to);
            if (g) i_req1 = 1'b0; else i_req0 = 1'b0;
            model_last = g;
            e.data = fb;
            n_checks++;
            if (to) $display("FAIL contention_txn%0d: no ack within bound", k);
            else if (o !== e) $display("FAIL contention_txn%0d: got %h, expected %h", k, o, e);
            else n_pass++;
            if (k == 0) ac_first = ac;
            else begin
                n_checks++;
                if (ac - ac_first !== SPACING)
                    $display("FAIL contention_spacing: got %0d, expected %0d", ac - ac_first, SPACING);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        wait_idle();
        ack_seen = 1'b0;
        i_addr1 = 24'($urandom);  i_req1 = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge i_clk); #1;
            if (!o_tex_csb && rise_cnt == 19) begin found = 1'b1; break; end
        end
        #2 i_reset_n = 1'b0;
        #1;
        n_checks++;
        if (!found) $display("FAIL reset_mid_pads: ADDR bit 10 not reached within bound");
        else if ({o_tex_csb, o_tex_sclk, o_tex_oeb0} !== 3'b100)
            $display("FAIL reset_mid_pads: got %b, expected 100", {o_tex_csb, o_tex_sclk, o_tex_oeb0});
        else n_pass++;
        i_req1 = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk); #2 i_reset_n = 1'b1;
        model_last = 1'b1;
        repeat (5) @(posedge i_clk);
        #1;
        n_checks++;
        if (ack_seen !== 1'b0) $display("FAIL reset_mid_no_ack: got ack %b, expected 0", ack_seen);
        else n_pass++;
        begin
            txn_t o, e; logic [7:0] fb; int ac, gp; bit to, g; logic [23:0] a;
            a = 24'($urandom);  i_addr1 = a;  i_req1 = 1'b1;
            g = model_grant(1'b0, 1'b1);
            wait_txn(o, fb, ac, gp, to);
            i_req1 = 1'b0;  model_last = g;
            e = make_exp(g, fb, a);
            n_checks++;
            if (to) $display("FAIL reset_mid_reissue: no ack within bound");
            else if (o !== e) $display("FAIL reset_mid_reissue: got %h, expected %h", o, e);
            else n_pass++;
        end
    endtask

    task automatic test_both_held();
        txn_t o, e; logic [7:0] fb; int ac, gp; bit to, g;
        wait_idle();
        i_addr0 = 24'($urandom);  i_addr1 = 24'($urandom);
        i_req0 = 1'b1;  i_req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            g = model_grant(1'b1, 1'b1);
            e = make_exp(g, 8'h00, g ? i_addr1 : i_addr0);
            wait_txn(o, fb, ac, gp, to);
            model_last = g;
            if (g) i_addr1 = 24'($urandom); else i_addr0 = 24'($urandom);
            if (k == 3) begin i_req0 = 1'b0; i_req1 = 1'b0; end
            e.data = fb;
            n_checks++;
            if (to) $display("FAIL both_held_txn%0d: no ack within bound", k);
            else if (o !== e) $display("FAIL both_held_txn%0d: got %h, expected %h", k, o, e);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        txn_t o, e; logic [7:0] fb; int ac, ac_first, gp; bit to;
        wait_idle();
        i_addr1 = 24'h000000;  i_req1 = 1'b1;
        wait_txn(o, fb, ac, gp, to);
        i_addr1 = 24'hFFFFFF;  model_last = 1'b1;  ac_first = ac;
        e = make_exp(1'b1, fb, 24'h000000);
        n_checks++;
        if (to) $display("FAIL b2b_first: no ack within bound");
        else if (o !== e) $display("FAIL b2b_first: got %h, expected %h", o, e);
        else n_pass++;
        wait_txn(o, fb, ac, gp, to);
        i_req1 = 1'b0;
        e = make_exp(1'b1, fb, 24'hFFFFFF);
        n_checks++;
        if (to) $display("FAIL b2b_second: no ack within bound");
        else if (o !== e) $display("FAIL b2b_second: got %h, expected %h", o, e);
        else n_pass++;
        n_checks++;
        if (gp !== MIN_GAP + 1) $display("FAIL b2b_csb_high: got %0d cycles, expected %0d", gp, MIN_GAP + 1);
        else n_pass++;
        n_checks++;
        if (ac - ac_first !== SPACING)
            $display("FAIL b2b_spacing: got %0d, expected %0d", ac - ac_first, SPACING);
        else n_pass++;
    endtask

    task automatic test_late_addr();
        txn_t o, e; logic [7:0] fb; int ac, gp; bit to, g; logic [23:0] a;
        wait_idle();
        a = 24'($urandom);  i_addr0 = a;  i_req0 = 1'b1;
        g = model_grant(1'b1, 1'b0);
        @(posedge i_clk); #1;
        i_addr0 = ~a;
        wait_txn(o, fb, ac, gp, to);
        i_req0 = 1'b0;  model_last = g;
        e = make_exp(g, fb, a);
        n_checks++;
        if (to) $display("FAIL late_addr: no ack within bound");
        else if (o !== e) $display("FAIL late_addr: got %h, expected %h", o, e);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_reset_mid();
        test_both_held();
        test_back_to_back();
        test_late_addr();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
